// File: rtl/btn_clk_pkg.sv
// rtl/btn_clk_pkg.sv - shared defaults, width helpers and btn_held state encoding
package btn_clk_pkg;

  localparam int CLK_HZ_DEF   = 6_250_000;
  localparam int SLOW_HZ_DEF  = 45;
  localparam int DEBOUNCE_DEF = 125_000;
  localparam int REPEAT_DEF   = 1_562_500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEEN  = 2'd2
  } held_state_e;

  // Half period of the slow clock in fast cycles (integer division).
  function automatic int half_of(input int clk_hz, input int slow_hz);
    return clk_hz / (2 * slow_hz);
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop sync, debounce, press pulse and press event
// Auto-repeat counter present only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
  import btn_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_press_pulse_o,
  output logic press_evt_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rise_d;

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      dcnt_d  = '0;
      level_d = sync2_q;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  assign rise_d = level_d & ~level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_d;

  // A repeat is suppressed in the cycle the level is falling.
  assign rep_d  = level_q & level_d & (rcnt_q == RW'(REPEAT_CYCLES - 1));
  assign rcnt_d = (!level_q || rcnt_q == RW'(REPEAT_CYCLES - 1)) ? '0 : rcnt_q + RW'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) rcnt_q <= '0;
    else         rcnt_q <= rcnt_d;
  end

  assign press_evt_o = rise_d | rep_d;
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES > 0);
  assign press_evt_o   = rise_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= press_evt_o;
      dcnt_q  <= dcnt_d;
    end
  end

  assign btn_level_o       = level_q;
  assign btn_press_pulse_o = pulse_q;

endmodule

// File: rtl/btn_slowclk_conditioner.sv
// rtl/btn_slowclk_conditioner.sv - slow clock divider plus button conditioning for slow-clock consumers
// Optional auto-repeat of press events via BTN_AUTOREPEAT_EN.
module btn_slowclk_conditioner
  import btn_clk_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEF,
  parameter int SLOW_HZ         = SLOW_HZ_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic clk_mhz_6_25,
  input  logic reset,
  input  logic btn_raw,
  output logic clk_hz_45,
  output logic btn_level,
  output logic btn_press_pulse,
  output logic btn_held
);

  localparam int HALF   = half_of(CLK_HZ, SLOW_HZ);
  localparam int HALF_W = cnt_width(HALF);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              slow_q, slow_d;
  logic              wrap;
  logic              rise_evt, fall_evt;
  logic              press_evt;

  held_state_e state_q;
  logic        held_q;
  logic        seen_rise_q;

  assign wrap     = (cnt_q == HALF_W'(HALF - 1));
  assign rise_evt = wrap & ~slow_q;
  assign fall_evt = wrap & slow_q;

  always_comb begin
    cnt_d  = cnt_q + HALF_W'(1);
    slow_d = slow_q;
    if (wrap) begin
      cnt_d  = '0;
      slow_d = ~slow_q;
    end
  end

  always_ff @(posedge clk_mhz_6_25) begin
    if (reset) begin
      cnt_q  <= '0;
      slow_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slow_q <= slow_d;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_debounce (
    .clk_i            (clk_mhz_6_25),
    .reset_i          (reset),
    .btn_raw_i        (btn_raw),
    .btn_level_o      (btn_level),
    .btn_press_pulse_o(btn_press_pulse),
    .press_evt_o      (press_evt)
  );

  // A rise coinciding with the press is not counted: the consumer may miss it.
  always_ff @(posedge clk_mhz_6_25) begin
    if (reset) begin
      state_q     <= IDLE;
      held_q      <= 1'b0;
      seen_rise_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_evt) begin
            state_q     <= ARMED;
            held_q      <= 1'b1;
            seen_rise_q <= 1'b0;
          end
        end
        ARMED: begin
          if (rise_evt) begin
            state_q     <= SEEN;
            seen_rise_q <= 1'b1;
          end
        end
        SEEN: begin
          if (fall_evt && seen_rise_q) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          held_q      <= 1'b0;
          seen_rise_q <= 1'b0;
        end
      endcase
    end
  end

  assign clk_hz_45 = slow_q;
  assign btn_held  = held_q;

endmodule
